boot_loader_ctrl: RTL and testbench

Boot sequencer that copies the 256-word Hack bootloader image from the boot ROM into instruction RAM at power-up, then releases the CPU. It sits between the boot ROM, the instruction-RAM write port and the CPU reset/hold input. It also owns the ROM address bus while copying. Software or debug logic can re-run the copy with a `start` pulse.

---
 rtl/boot_pkg.sv | 14 +
 rtl/boot_word_counter.sv | 29 ++
 rtl/boot_loader_ctrl.sv | 98 +++++++++
 tb/tb_boot_loader_ctrl.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/boot_pkg.sv
// Shared definitions for the boot sequencer: state encoding and the
// image geometry used to size both this block and the boot ROM.
package boot_pkg;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2
  } boot_state_e;

  localparam int          BOOT_WORDS = 256;
  localparam logic [15:0] BOOT_BASE  = 16'h0000;

endpackage

// File: rtl/boot_word_counter.sv
// 8-bit word index for the boot copy, with synchronous clear/increment
// and a terminal flag raised on the last word of the image.
module boot_word_counter #(
  parameter int WORDS = 256
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr_i,
  input  logic       inc_i,
  output logic [7:0] cnt_o,
  output logic       term_o
);

  logic [7:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 8'd0;
    end else if (clr_i) begin
      cnt_q <= 8'd0;
    end else if (inc_i) begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

  assign cnt_o  = cnt_q;
  assign term_o = (cnt_q == 8'(WORDS - 1));

endmodule

// File: rtl/boot_loader_ctrl.sv
// Copies the boot image from ROM into instruction RAM, holding the CPU
// in reset until the last word has been accepted by the RAM.
module boot_loader_ctrl
  import boot_pkg::*;
#(
  parameter int          WORDS     = BOOT_WORDS,
  parameter logic [15:0] DEST_BASE = BOOT_BASE
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [15:0] rom_addr,
  input  logic [15:0] rom_data,
  output logic [15:0] ram_addr,
  output logic [15:0] ram_wdata,
  output logic        ram_we,
  input  logic        ram_ready,
  output logic        cpu_hold,
  output logic        boot_done
);

  boot_state_e state_q;
  logic [15:0] wreg_q;
  logic        ram_we_q;
  logic        cpu_hold_q;
  logic        boot_done_q;

  logic [7:0]  cnt;
  logic        cnt_term;
  logic        cnt_clr;
  logic        cnt_inc;

  assign cnt_clr = (state_q == ST_DONE) && start;
  assign cnt_inc = (state_q == ST_WRITE) && ram_ready && !cnt_term;

  boot_word_counter #(
    .WORDS (WORDS)
  ) u_counter (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (cnt_clr),
    .inc_i  (cnt_inc),
    .cnt_o  (cnt),
    .term_o (cnt_term)
  );

  // Output flags are registered alongside the state so no input reaches a port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_FETCH;
      wreg_q      <= 16'h0000;
      ram_we_q    <= 1'b0;
      cpu_hold_q  <= 1'b1;
      boot_done_q <= 1'b0;
    end else begin
      case (state_q)
        ST_FETCH: begin
          wreg_q   <= rom_data;
          ram_we_q <= 1'b1;
          state_q  <= ST_WRITE;
        end
        ST_WRITE: begin
          if (ram_ready) begin
            ram_we_q <= 1'b0;
            if (cnt_term) begin
              cpu_hold_q  <= 1'b0;
              boot_done_q <= 1'b1;
              state_q     <= ST_DONE;
            end else begin
              state_q <= ST_FETCH;
            end
          end
        end
        ST_DONE: begin
          if (start) begin
            cpu_hold_q  <= 1'b1;
            boot_done_q <= 1'b0;
            state_q     <= ST_FETCH;
          end
        end
        default: begin
          ram_we_q    <= 1'b0;
          cpu_hold_q  <= 1'b1;
          boot_done_q <= 1'b0;
          state_q     <= ST_FETCH;
        end
      endcase
    end
  end

  assign rom_addr  = {8'h00, cnt};
  assign ram_addr  = DEST_BASE + {8'h00, cnt};
  assign ram_wdata = wreg_q;
  assign ram_we    = ram_we_q;
  assign cpu_hold  = cpu_hold_q;
  assign boot_done = boot_done_q;

endmodule

// File: tb/tb_boot_loader_ctrl.sv
// Bench for boot_loader_ctrl: word-by-word copy model checked every cycle,
// plus literal pins for reset values, completion cycles and small parameters.
module tb_boot_loader_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        ram_ready;
  logic [15:0] rom_addr, rom_data, ram_addr, ram_wdata;
  logic        ram_we, cpu_hold, boot_done;
  logic [15:0] rom [256];

  logic [15:0] s_rom_addr, s_rom_data, s_ram_addr, s_ram_wdata;
  logic        s_ram_we, s_cpu_hold, s_boot_done;
  logic        s_ram_ready, s_start;

  int checks   = 0;
  int failures = 0;
  int mode      = 0;
  int start_req = 0;

  assign rom_data    = rom[rom_addr[7:0]];
  assign s_rom_data  = s_rom_addr ^ 16'h1234;
  assign s_ram_ready = 1'b1;
  assign s_start     = 1'b0;

  boot_loader_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_we    (ram_we),
    .ram_ready (ram_ready),
    .cpu_hold  (cpu_hold),
    .boot_done (boot_done)
  );

  boot_loader_ctrl #(
    .WORDS     (4),
    .DEST_BASE (16'hFFFE)
  ) dut_small (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (s_start),
    .rom_addr  (s_rom_addr),
    .rom_data  (s_rom_data),
    .ram_addr  (s_ram_addr),
    .ram_wdata (s_ram_wdata),
    .ram_we    (s_ram_we),
    .ram_ready (s_ram_ready),
    .cpu_hold  (s_cpu_hold),
    .boot_done (s_boot_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h time=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the copy as a plain program, one fetch cycle then write
  // cycles until accepted, per word; then DONE until a start is seen.
  logic [15:0] m_rom_addr, m_ram_addr, m_wdata;
  logic        m_we, m_hold, m_done;
  int          m_stalls;

  initial begin : model
    bit abort;
    m_we = 0; m_hold = 1; m_done = 0;
    m_rom_addr = 0; m_ram_addr = 0; m_wdata = 0; m_stalls = 0;
    forever begin
      wait (rst_n === 1'b1);
      abort = 0;
      while (!abort) begin
        m_stalls = 0;
        for (int k = 0; k < 256 && !abort; k++) begin
          m_rom_addr = 16'(k); m_ram_addr = 16'(k);
          m_we = 0; m_hold = 1; m_done = 0;
          @(posedge clk);
          abort = !rst_n;
          if (!abort) begin
            m_wdata = rom[k];
            m_we = 1;
            forever begin
              @(posedge clk);
              if (!rst_n) begin abort = 1; break; end
              if (ram_ready) break;
              m_stalls++;
            end
          end
        end
        if (!abort) begin
          m_we = 0; m_hold = 0; m_done = 1;
          forever begin
            @(posedge clk);
            if (!rst_n) begin abort = 1; break; end
            if (start) break;
          end
        end
      end
      m_we = 0; m_hold = 1; m_done = 0;
    end
  end

  initial begin : compare
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_rom_addr", rom_addr, 16'h0000);
        chk("rst_ram_we", ram_we, 1'b0);
        chk("rst_ram_addr", ram_addr, 16'h0000);
        chk("rst_ram_wdata", ram_wdata, 16'h0000);
        chk("rst_cpu_hold", cpu_hold, 1'b1);
        chk("rst_boot_done", boot_done, 1'b0);
      end else begin
        chk("cyc_ram_we", ram_we, m_we);
        chk("cyc_cpu_hold", cpu_hold, m_hold);
        chk("cyc_boot_done", boot_done, m_done);
        if (!m_done) chk("cyc_rom_addr", rom_addr, m_rom_addr);
        if (m_we) begin
          chk("cyc_ram_addr", ram_addr, m_ram_addr);
          chk("cyc_ram_wdata", ram_wdata, m_wdata);
        end
      end
    end
  end

  // Write scoreboard; cycle 0 is the first edge after reset release.
  int          cyc, run_base, run_writes, done_cyc;
  int          first_wr_cyc, last_wr_cyc;
  logic [15:0] first_wr_addr, first_wr_data;
  bit          done_seen;
  int          wr_cnt [256];
  logic [15:0] wr_data [256];

  task automatic clear_run();
    for (int i = 0; i < 256; i++) wr_cnt[i] = 0;
    run_writes = 0;
    done_seen = 0;
  endtask

  initial begin : monitor
    cyc = -1; run_base = 0; done_cyc = 0;
    first_wr_cyc = 0; last_wr_cyc = 0; first_wr_addr = 0; first_wr_data = 0;
    clear_run();
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        cyc = -1; run_base = 0;
        clear_run();
      end else begin
        cyc++;
        if (ram_we && ram_ready) begin
          if (run_writes == 0) begin
            first_wr_cyc = cyc; first_wr_addr = ram_addr; first_wr_data = ram_wdata;
          end
          last_wr_cyc = cyc;
          wr_cnt[ram_addr[7:0]]++;
          wr_data[ram_addr[7:0]] = ram_wdata;
          run_writes++;
          $display("write cyc=%0d addr=%04h data=%04h", cyc - run_base, ram_addr, ram_wdata);
        end
        if (boot_done && !done_seen) begin
          done_seen = 1; done_cyc = cyc;
        end
        if (boot_done && start) begin
          clear_run();
          run_base = cyc + 1;
        end
      end
    end
  end

  int          s_cyc, s_done_cyc;
  bit          s_seen;
  logic [15:0] s_addrs[$];
  logic [15:0] s_datas[$];

  initial begin : monitor_small
    s_cyc = -1; s_done_cyc = 0; s_seen = 0;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        s_cyc = -1; s_seen = 0;
        s_addrs.delete(); s_datas.delete();
      end else begin
        s_cyc++;
        if (s_ram_we && s_ram_ready && s_addrs.size() < 8) begin
          s_addrs.push_back(s_ram_addr);
          s_datas.push_back(s_ram_wdata);
        end
        if (s_boot_done && !s_seen) begin s_seen = 1; s_done_cyc = s_cyc; end
      end
    end
  end

  initial begin : drive
    logic [15:0] stall_word;
    int stall_n, prev_mode, ack;
    ram_ready = 1; start = 0;
    stall_word = 16'hFFFF; stall_n = 0; prev_mode = 0; ack = 0;
    forever begin
      @(negedge clk);
      if (mode != prev_mode) begin stall_word = 16'hFFFF; prev_mode = mode; end
      start = 0;
      if (start_req != ack) begin
        start = 1; ack = start_req;
      end else if (mode == 2 && !boot_done) begin
        start = ($urandom_range(0, 7) == 0);
      end
      case (mode)
        1: begin
          if (ram_we && rom_addr[1:0] == 2'b00 && !(stall_word == rom_addr && stall_n >= 3)) begin
            if (stall_word != rom_addr) begin stall_word = rom_addr; stall_n = 0; end
            ram_ready = 0;
            stall_n++;
          end else begin
            ram_ready = 1;
          end
        end
        2: ram_ready = ($urandom_range(0, 3) != 0);
        default: ram_ready = 1;
      endcase
    end
  end

  function automatic int image_bad(input bit use_literal);
    int bad = 0;
    for (int i = 0; i < 256; i++) begin
      if (wr_cnt[i] != 1) bad++;
      else if (wr_data[i] !== (use_literal ? (16'(i) ^ 16'hA5A5) : rom[i])) bad++;
    end
    return bad;
  endfunction

  task automatic wait_done(input int limit, input string name);
    for (int i = 0; i < limit && !done_seen; i++) @(negedge clk);
    chk(name, 32'(done_seen), 32'd1);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #3 rst_n = 0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1;
  endtask

  initial begin : main
    rst_n = 0;
    for (int i = 0; i < 256; i++) rom[i] = 16'(i) ^ 16'hA5A5;
    repeat (2) @(negedge clk);
    chk("reset_cpu_hold", cpu_hold, 1'b1);
    chk("reset_ram_addr", ram_addr, 16'h0000);
    chk("reset_small_ram_addr", s_ram_addr, 16'hFFFE);
    @(posedge clk); #3 rst_n = 1;

    // Clean boot with ram_ready tied high.
    wait_done(2000, "clean_timeout");
    chk("clean_done_cycle", 32'(done_cyc - run_base), 32'd512);
    chk("clean_model_cycle", 32'(done_cyc - run_base), 32'(512 + m_stalls));
    chk("clean_writes", 32'(run_writes), 32'd256);
    chk("clean_first_write_cyc", 32'(first_wr_cyc), 32'd1);
    chk("clean_last_write_cyc", 32'(last_wr_cyc), 32'd511);
    chk("clean_image_bad", 32'(image_bad(1)), 32'd0);
    chk("small_done_cycle", 32'(s_done_cyc), 32'd8);
    chk("small_writes", 32'(s_addrs.size()), 32'd4);
    if (s_addrs.size() == 4) begin
      chk("small_addr0", s_addrs[0], 16'hFFFE);
      chk("small_addr1", s_addrs[1], 16'hFFFF);
      chk("small_addr2", s_addrs[2], 16'h0000);
      chk("small_addr3", s_addrs[3], 16'h0001);
      chk("small_data3", s_datas[3], 16'h1237);
    end
    chk("small_cpu_hold", s_cpu_hold, 1'b0);

    // Backpressure: 3 stall cycles on every 4th word.
    mode = 1;
    pulse_reset();
    wait_done(3000, "bp_timeout");
    chk("bp_done_cycle", 32'(done_cyc - run_base), 32'd704);
    chk("bp_model_stalls", 32'(m_stalls), 32'd192);
    chk("bp_image_bad", 32'(image_bad(1)), 32'd0);

    // Random ready and ignored start pulses over random ROM contents.
    mode = 2;
    for (int i = 0; i < 256; i++) rom[i] = 16'($urandom);
    pulse_reset();
    wait_done(5000, "rand_timeout");
    chk("rand_done_cycle", 32'(done_cyc - run_base), 32'(512 + m_stalls));
    chk("rand_image_bad", 32'(image_bad(0)), 32'd0);

    // Restart from DONE with new ROM contents.
    mode = 0;
    for (int i = 0; i < 256; i++) rom[i] = 16'($urandom);
    @(posedge clk); #3 start_req++;
    @(negedge clk);
    @(posedge clk);
    @(negedge clk); #1;
    chk("restart_boot_done_low", boot_done, 1'b0);
    chk("restart_cpu_hold_high", cpu_hold, 1'b1);
    wait_done(2000, "restart_timeout");
    chk("restart_done_cycle", 32'(done_cyc - run_base), 32'd512);
    chk("restart_image_bad", 32'(image_bad(0)), 32'd0);

    // Reset during WRITE of word 100.
    mode = 2;
    pulse_reset();
    for (int i = 0; i < 3000 && !(ram_we && rom_addr == 16'd100); i++) @(negedge clk);
    chk("reach_word100", {15'd0, ram_we}, 32'd1);
    #2 rst_n = 0;
    #1;
    chk("async_rst_ram_we", ram_we, 1'b0);
    chk("async_rst_rom_addr", rom_addr, 16'h0000);
    chk("async_rst_ram_addr", ram_addr, 16'h0000);
    chk("async_rst_cpu_hold", cpu_hold, 1'b1);
    mode = 0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1;
    wait_done(2000, "midrst_timeout");
    chk("midrst_first_addr", first_wr_addr, 16'h0000);
    chk("midrst_first_data", first_wr_data, rom[0]);
    chk("midrst_first_cyc", 32'(first_wr_cyc), 32'd1);
    chk("midrst_done_cycle", 32'(done_cyc - run_base), 32'd512);
    chk("midrst_image_bad", 32'(image_bad(0)), 32'd0);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
